// File: rtl/z_m_csa_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer driving one shared 4-bit carry-select stage.
// Define Z_M_CSA_SUB_EN to add the 'sub' port (A - B via inverted B and carry-in of 1).
module z_m_csa_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
`ifdef Z_M_CSA_SUB_EN
  input  logic             sub,
`endif
  output logic [3:0]       stg_a,
  output logic [3:0]       stg_b,
  output logic             stg_cin,
  input  logic [3:0]       stg_sum,
  input  logic             stg_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [WIDTH-1:0] op_a_r, op_b_r;
  logic [IW+1:0]   bit_base;
  logic            sub_sel;

`ifdef Z_M_CSA_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Bit offset of the current nibble.
  assign bit_base = {idx, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (idx == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    stg_a   = '0;
    stg_b   = '0;
    stg_cin = 1'b0;
    unique case (state)
      RUN: begin
        busy    = 1'b1;
        stg_a   = op_a_r[bit_base +: 4];
        stg_b   = op_b_r[bit_base +: 4];
        stg_cin = carry;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      op_a_r <= '0;
      op_b_r <= '0;
      result <= '0;
      c_out  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            op_a_r <= op_a;
            op_b_r <= sub_sel ? ~op_b : op_b;
            carry  <= sub_sel ? 1'b1 : c_in;
            result <= '0;
            c_out  <= 1'b0;
          end
        end
        RUN: begin
          result[bit_base +: 4] <= stg_sum;
          carry <= stg_cout;
          if (idx == LAST) c_out <= stg_cout;
          else             idx   <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
